// File: rtl/sdrc_wb_mport.sv
// Multi-port Wishbone front end for sdrc_core: arbitrates NP masters onto one app request port.
// Define SDRC_MPORT_RR_EN for round-robin arbitration; otherwise fixed priority (port 0 highest).
module sdrc_wb_mport #(
   parameter int unsigned NP = 4,
   parameter int unsigned AW = 30,
   parameter int unsigned dw = 32,
   parameter int unsigned bl = 9
) (
   input  logic               sdram_clk,
   input  logic               sdram_resetn,
   input  logic [NP-1:0]      wb_cyc_i,
   input  logic [NP-1:0]      wb_stb_i,
   input  logic [NP-1:0]      wb_we_i,
   input  logic [NP*AW-1:0]   wb_addr_i,
   input  logic [NP*dw-1:0]   wb_dat_i,
   input  logic [NP*dw/8-1:0] wb_sel_i,
   output logic [NP-1:0]      wb_ack_o,
   output logic [dw-1:0]      wb_dat_o,
   output logic [NP-1:0]      arb_grant_o,
   output logic               app_req,
   output logic [AW-1:0]      app_req_addr,
   output logic [bl-1:0]      app_req_len,
   output logic               app_req_wr_n,
   input  logic               app_req_ack,
   output logic [dw-1:0]      app_wr_data,
   output logic [dw/8-1:0]    app_wr_en_n,
   input  logic               app_wr_next_req,
   input  logic               app_rd_valid,
   input  logic               app_last_rd,
   input  logic [dw-1:0]      app_rd_data
);

   localparam int unsigned PW = (NP > 1) ? $clog2(NP) : 1;
   localparam int unsigned SW = dw / 8;

   typedef enum logic [2:0] {StIdle, StReq, StWdata, StRdata, StAck} state_e;

   state_e          state_q, state_d;
   logic            req_q, req_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic            wr_n_q, wr_n_d;
   logic [dw-1:0]   wdata_q, wdata_d;
   logic [SW-1:0]   sel_q, sel_d;
   logic [SW-1:0]   wr_en_n_q, wr_en_n_d;
   logic [NP-1:0]   ack_q, ack_d;
   logic [dw-1:0]   dat_q, dat_d;
   logic [NP-1:0]   grant_q, grant_d;

   logic [NP-1:0]   pending;
   logic            win_found;
   logic [PW-1:0]   win_idx;
   logic [AW-1:0]   win_addr;
   logic [dw-1:0]   win_dat;
   logic [SW-1:0]   win_sel;
   logic            win_we;

   // Single-beat transfers only: the core always returns exactly one beat we care about.
   logic unused_last_rd;
   assign unused_last_rd = app_last_rd;

   assign pending = wb_cyc_i & wb_stb_i;

`ifdef SDRC_MPORT_RR_EN
   logic [PW-1:0] ptr_q, ptr_d;
   int            cand;

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int i = 0; i < int'(NP); i++) begin
         cand = int'(ptr_q) + i;
         if (cand >= int'(NP)) cand = cand - int'(NP);
         if (!win_found && pending[cand]) begin
            win_found = 1'b1;
            win_idx   = PW'(cand);
         end
      end
   end
`else
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = int'(NP) - 1; i >= 0; i--) begin
         if (pending[i]) begin
            win_found = 1'b1;
            win_idx   = PW'(i);
         end
      end
   end
`endif

   always_comb begin
      win_addr = '0;
      win_dat  = '0;
      win_sel  = '0;
      win_we   = 1'b0;
      for (int p = 0; p < int'(NP); p++) begin
         if (win_idx == PW'(p)) begin
            win_addr = wb_addr_i[p*AW +: AW];
            win_dat  = wb_dat_i[p*dw +: dw];
            win_sel  = wb_sel_i[p*SW +: SW];
            win_we   = wb_we_i[p];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      addr_d    = addr_q;
      wr_n_d    = wr_n_q;
      wdata_d   = wdata_q;
      sel_d     = sel_q;
      wr_en_n_d = wr_en_n_q;
      ack_d     = '0;
      dat_d     = dat_q;
      grant_d   = grant_q;
`ifdef SDRC_MPORT_RR_EN
      ptr_d     = ptr_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (win_found) begin
               state_d          = StReq;
               req_d            = 1'b1;
               addr_d           = win_addr;
               wr_n_d           = ~win_we;
               wdata_d          = win_dat;
               sel_d            = win_sel;
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
`ifdef SDRC_MPORT_RR_EN
               ptr_d = (win_idx == PW'(NP - 1)) ? '0 : win_idx + PW'(1);
`endif
            end
         end
         StReq: begin
            if (app_req_ack) begin
               req_d = 1'b0;
               if (!wr_n_q) begin
                  state_d   = StWdata;
                  wr_en_n_d = ~sel_q;
               end else begin
                  state_d = StRdata;
               end
            end
         end
         StWdata: begin
            if (app_wr_next_req) begin
               state_d   = StAck;
               wr_en_n_d = '1;
               // A master that abandoned its cycle still lets the access finish, but gets no ack.
               ack_d     = grant_q & wb_cyc_i;
            end
         end
         StRdata: begin
            if (app_rd_valid) begin
               state_d = StAck;
               dat_d   = app_rd_data;
               ack_d   = grant_q & wb_cyc_i;
            end
         end
         StAck: begin
            state_d = StIdle;
            grant_d = '0;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge sdram_clk) begin
      if (!sdram_resetn) begin
         state_q   <= StIdle;
         req_q     <= 1'b0;
         addr_q    <= '0;
         wr_n_q    <= 1'b1;
         wdata_q   <= '0;
         sel_q     <= '0;
         wr_en_n_q <= '1;
         ack_q     <= '0;
         dat_q     <= '0;
         grant_q   <= '0;
`ifdef SDRC_MPORT_RR_EN
         ptr_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         addr_q    <= addr_d;
         wr_n_q    <= wr_n_d;
         wdata_q   <= wdata_d;
         sel_q     <= sel_d;
         wr_en_n_q <= wr_en_n_d;
         ack_q     <= ack_d;
         dat_q     <= dat_d;
         grant_q   <= grant_d;
`ifdef SDRC_MPORT_RR_EN
         ptr_q     <= ptr_d;
`endif
      end
   end

   assign wb_ack_o     = ack_q;
   assign wb_dat_o     = dat_q;
   assign arb_grant_o  = grant_q;
   assign app_req      = req_q;
   assign app_req_addr = addr_q;
   assign app_req_len  = bl'(1);
   assign app_req_wr_n = wr_n_q;
   assign app_wr_data  = wdata_q;
   assign app_wr_en_n  = wr_en_n_q;

endmodule

// File: tb/tb_sdrc_wb_mport.sv
// Scoreboard bench for sdrc_wb_mport: directed stimulus queues expected acks, a monitor checks them.
module tb_sdrc_wb_mport;

   localparam int NP = 4;
   localparam int AW = 30;
   localparam int DW = 32;
   localparam int BL = 9;

   logic              clk;
   logic              resetn;
   logic [NP-1:0]     cyc, stb, we;
   logic [NP*AW-1:0]  addr;
   logic [NP*DW-1:0]  wdat;
   logic [NP*DW/8-1:0] sel;
   logic [NP-1:0]     ack;
   logic [DW-1:0]     rdat;
   logic [NP-1:0]     grant;
   logic              app_req;
   logic [AW-1:0]     app_req_addr;
   logic [BL-1:0]     app_req_len;
   logic              app_req_wr_n;
   logic              app_req_ack;
   logic [DW-1:0]     app_wr_data;
   logic [DW/8-1:0]   app_wr_en_n;
   logic              app_wr_next_req;
   logic              app_rd_valid;
   logic              app_last_rd;
   logic [DW-1:0]     app_rd_data;

   typedef struct {
      logic [NP-1:0] port;
      logic          rd;
      logic [DW-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   sdrc_wb_mport #(.NP(NP), .AW(AW), .dw(DW), .bl(BL)) dut (
      .sdram_clk       (clk),
      .sdram_resetn    (resetn),
      .wb_cyc_i        (cyc),
      .wb_stb_i        (stb),
      .wb_we_i         (we),
      .wb_addr_i       (addr),
      .wb_dat_i        (wdat),
      .wb_sel_i        (sel),
      .wb_ack_o        (ack),
      .wb_dat_o        (rdat),
      .arb_grant_o     (grant),
      .app_req         (app_req),
      .app_req_addr    (app_req_addr),
      .app_req_len     (app_req_len),
      .app_req_wr_n    (app_req_wr_n),
      .app_req_ack     (app_req_ack),
      .app_wr_data     (app_wr_data),
      .app_wr_en_n     (app_wr_en_n),
      .app_wr_next_req (app_wr_next_req),
      .app_rd_valid    (app_rd_valid),
      .app_last_rd     (app_last_rd),
      .app_rd_data     (app_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [3:0] s);
      cyc[p] = 1'b1;
      stb[p] = 1'b1;
      we[p]  = w;
      addr[p*AW +: AW] = a;
      wdat[p*DW +: DW] = d;
      sel[p*4 +: 4]    = s;
   endtask

   task automatic push(input logic [NP-1:0] port, input logic rd, input logic [DW-1:0] d);
      exp_t e;
      e.port = port;
      e.rd   = rd;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Monitor: every ack the DUT presents must match the oldest expected response.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (ack != '0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_ack", 64'(ack), 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("ack_port", 64'(ack), 64'(e.port));
               if (e.rd) chk("ack_rdata", 64'(rdat), 64'(e.data));
            end
         end
      end
   end

   logic [NP-1:0] rr_exp [5];

   initial begin
      resetn = 1'b0;
      cyc = '0; stb = '0; we = '0; addr = '0; wdat = '0; sel = '0;
      app_req_ack = 1'b0; app_wr_next_req = 1'b0; app_rd_valid = 1'b0;
      app_last_rd = 1'b0; app_rd_data = '0;
      tick(); tick();
      chk("rst_app_req", 64'(app_req), 64'd0);
      chk("rst_wr_n", 64'(app_req_wr_n), 64'd1);
      chk("rst_addr", 64'(app_req_addr), 64'd0);
      chk("rst_wr_data", 64'(app_wr_data), 64'd0);
      chk("rst_wr_en_n", 64'(app_wr_en_n), 64'hF);
      chk("rst_ack", 64'(ack), 64'd0);
      chk("rst_dat", 64'(rdat), 64'd0);
      chk("rst_grant", 64'(grant), 64'd0);
      chk("req_len", 64'(app_req_len), 64'd1);
      resetn = 1'b1;

      // Single write from port 2
      set_port(2, 1'b1, 30'h0000123, 32'hDEADBEEF, 4'hF);
      push(4'b0100, 1'b0, '0);
      tick();
      chk("wr_req", 64'(app_req), 64'd1);
      chk("wr_grant", 64'(grant), 64'b0100);
      chk("wr_wr_n", 64'(app_req_wr_n), 64'd0);
      chk("wr_addr", 64'(app_req_addr), 64'h123);
      app_req_ack = 1'b1;
      tick();
      app_req_ack = 1'b0;
      chk("wr_req_drop", 64'(app_req), 64'd0);
      chk("wr_en_n", 64'(app_wr_en_n), 64'h0);
      chk("wr_data", 64'(app_wr_data), 64'hDEADBEEF);
      app_wr_next_req = 1'b1;
      tick();
      app_wr_next_req = 1'b0;
      chk("wr_ack", 64'(ack), 64'b0100);
      chk("wr_en_n_after", 64'(app_wr_en_n), 64'hF);
      cyc[2] = 1'b0; stb[2] = 1'b0;
      tick();
      chk("wr_ack_pulse", 64'(ack), 64'd0);
      chk("wr_grant_clr", 64'(grant), 64'd0);

      // Read from port 0, one idle cycle in RDATA before data returns
      set_port(0, 1'b0, 30'h10, 32'h0, 4'hF);
      push(4'b0001, 1'b1, 32'hA5A50001);
      tick();
      chk("rd_req", 64'(app_req), 64'd1);
      chk("rd_wr_n", 64'(app_req_wr_n), 64'd1);
      chk("rd_addr", 64'(app_req_addr), 64'h10);
      chk("rd_grant", 64'(grant), 64'b0001);
      app_req_ack = 1'b1;
      tick();
      app_req_ack = 1'b0;
      tick();
      chk("rd_no_early_ack", 64'(ack), 64'd0);
      app_rd_valid = 1'b1; app_last_rd = 1'b1; app_rd_data = 32'hA5A50001;
      tick();
      app_rd_valid = 1'b0; app_last_rd = 1'b0;
      chk("rd_ack", 64'(ack), 64'b0001);
      chk("rd_dat", 64'(rdat), 64'hA5A50001);
      cyc[0] = 1'b0; stb[0] = 1'b0;
      tick();

      // Stray core strobes while idle
      app_rd_valid = 1'b1; app_wr_next_req = 1'b1; app_rd_data = 32'h12345678;
      tick(); tick();
      app_rd_valid = 1'b0; app_wr_next_req = 1'b0;
      chk("stray_ack", 64'(ack), 64'd0);
      chk("stray_dat", 64'(rdat), 64'hA5A50001);
      chk("stray_req", 64'(app_req), 64'd0);

      // Port 1 abandons its cycle in REQ: access completes silently
      set_port(1, 1'b0, 30'h40, 32'h0, 4'hF);
      tick();
      chk("drop_req", 64'(app_req), 64'd1);
      cyc[1] = 1'b0; stb[1] = 1'b0;
      tick();
      chk("drop_req_held", 64'(app_req), 64'd1);
      app_req_ack = 1'b1;
      tick();
      app_req_ack = 1'b0;
      chk("drop_req_clr", 64'(app_req), 64'd0);
      app_rd_valid = 1'b1; app_rd_data = 32'h0BADF00D;
      tick();
      app_rd_valid = 1'b0;
      chk("drop_no_ack", 64'(ack), 64'd0);
      tick();
      chk("drop_idle_grant", 64'(grant), 64'd0);

      // Write with no byte enables still acks
      set_port(1, 1'b1, 30'h55, 32'h11112222, 4'h0);
      push(4'b0010, 1'b0, '0);
      tick();
      chk("sel0_req", 64'(app_req), 64'd1);
      app_req_ack = 1'b1;
      tick();
      app_req_ack = 1'b0;
      chk("sel0_en_n", 64'(app_wr_en_n), 64'hF);
      chk("sel0_data", 64'(app_wr_data), 64'h11112222);
      app_wr_next_req = 1'b1;
      tick();
      app_wr_next_req = 1'b0;
      chk("sel0_ack", 64'(ack), 64'b0010);
      cyc[1] = 1'b0; stb[1] = 1'b0;
      tick();

      // Reset in the middle of a write data phase
      set_port(3, 1'b1, 30'h3FF, 32'hCAFEF00D, 4'b0101);
      tick();
      chk("rstw_grant", 64'(grant), 64'b1000);
      app_req_ack = 1'b1;
      tick();
      app_req_ack = 1'b0;
      chk("rstw_en_n", 64'(app_wr_en_n), 64'b1010);
      resetn = 1'b0;
      tick();
      chk("rstw_req", 64'(app_req), 64'd0);
      chk("rstw_en_n_clr", 64'(app_wr_en_n), 64'hF);
      chk("rstw_grant_clr", 64'(grant), 64'd0);
      chk("rstw_ack", 64'(ack), 64'd0);
      chk("rstw_addr", 64'(app_req_addr), 64'd0);
      cyc[3] = 1'b0; stb[3] = 1'b0;
      resetn = 1'b1;
      tick(); tick();
      chk("rstw_idle_req", 64'(app_req), 64'd0);

      // All ports pending continuously
`ifdef SDRC_MPORT_RR_EN
      rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
      rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
`else
      for (int k = 0; k < 5; k++) rr_exp[k] = 4'b0001;
`endif
      for (int p = 0; p < NP; p++) set_port(p, 1'b0, AW'(32'h200 + p), 32'h0, 4'hF);
      for (int k = 0; k < 5; k++) begin
         int n;
         n = 0;
         while (!app_req && n < 10) begin
            tick();
            n++;
         end
         chk("arb_req", 64'(app_req), 64'd1);
         chk("arb_grant", 64'(grant), 64'(rr_exp[k]));
         push(rr_exp[k], 1'b1, 32'hC0DE0000 + 32'(k));
         app_req_ack = 1'b1;
         tick();
         app_req_ack = 1'b0;
         app_rd_valid = 1'b1; app_last_rd = 1'b1; app_rd_data = 32'hC0DE0000 + 32'(k);
         tick();
         app_rd_valid = 1'b0; app_last_rd = 1'b0;
      end
      cyc = '0; stb = '0;
      tick(); tick(); tick();
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
